// File: rtl/hydra_pkt_gen_if.sv
// rtl/hydra_pkt_gen_if.sv - hydra ingress write bus (framing strobes, packed data, per-port pause)
interface hydra_pkt_gen_if #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        wr_sop;
  logic [NUM_PORTS-1:0]        wr_eop;
  logic [NUM_PORTS-1:0]        wr_vld;
  logic [NUM_PORTS*DATA_W-1:0] wr_data;
  logic [NUM_PORTS-1:0]        pause;

  modport master (output wr_sop, output wr_eop, output wr_vld, output wr_data, input pause);
  modport slave  (input wr_sop, input wr_eop, input wr_vld, input wr_data, output pause);
endinterface

// File: rtl/hydra_pkt_gen.sv
// rtl/hydra_pkt_gen.sv - multi-port framed packet generator; optional LFSR payload via HYDRA_PKT_GEN_LFSR_EN
module hydra_pkt_gen #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 9,
  parameter int PRI_W     = 3,
  parameter int DEST_W    = 4,
  parameter int CNT_W     = 16,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [PRI_W-1:0]     cfg_pri,
  input  logic [DEST_W-1:0]    cfg_dest,
  input  logic [CNT_W-1:0]     cfg_num,
  input  logic [CNT_W-1:0]     cfg_gap,
  input  logic [1:0]           cfg_mode,
  input  logic [DATA_W-1:0]    cfg_fill,
  hydra_pkt_gen_if.master      bus,
  output logic [NUM_PORTS-1:0] busy,
  output logic [NUM_PORTS-1:0] done,
  output logic [NUM_PORTS-1:0] err
);

  localparam int IDX_W = DATA_W - PORT_W;

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_DATA, S_EOP, S_GAP} state_t;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [PRI_W-1:0]    pri_q;
    logic [DEST_W-1:0]   dest_q;
    logic [CNT_W-1:0]    rem;
    logic [CNT_W-1:0]    gap_q;
    logic [CNT_W-1:0]    gap_cnt;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   fill_q;
    logic [LEN_W-1:0]    idx;
    logic                sop_q, eop_q, vld_q, done_q, err_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   idx_word;
    logic [DATA_W-1:0]   payload;
    logic                pause_p;

    assign pause_p = bus.pause[p];

    // Index pattern: port number in the top bits, word index below, wrapping at the field width
    assign idx_word = (DATA_W'(p) << IDX_W) |
                      (DATA_W'(idx) & {{PORT_W{1'b0}}, {IDX_W{1'b1}}});

`ifdef HYDRA_PKT_GEN_LFSR_EN
    localparam logic [15:0] SEED = 16'hACE1 ^ 16'(p);
    logic [15:0] lfsr;
    logic        lfsr_fb;
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif

    // Payload word for the current index according to the latched mode
    always_comb begin
      payload = idx_word;
      if (mode_q == 2'd2) begin
        payload = fill_q;
      end
`ifdef HYDRA_PKT_GEN_LFSR_EN
      else if (mode_q == 2'd1) begin
        payload = DATA_W'(lfsr);
      end
`endif
    end

    // Per-port framing FSM with registered strobes; sop is issued in the same cycle a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= S_IDLE;
        len_q   <= '0;
        pri_q   <= '0;
        dest_q  <= '0;
        rem     <= '0;
        gap_q   <= '0;
        gap_cnt <= '0;
        mode_q  <= '0;
        fill_q  <= '0;
        idx     <= '0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
        vld_q   <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
`ifdef HYDRA_PKT_GEN_LFSR_EN
        lfsr    <= SEED;
`endif
      end else begin
        sop_q  <= 1'b0;
        eop_q  <= 1'b0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
        // done trails the final eop by one cycle: eop just shown and nothing left to send
        done_q <= eop_q && (rem == '0);
        case (state)
          S_IDLE: begin
            if (start[p]) begin
              if (cfg_len == '0 || cfg_num == '0) begin
                err_q <= 1'b1;
              end else begin
                len_q  <= cfg_len;
                pri_q  <= cfg_pri;
                dest_q <= cfg_dest;
                rem    <= cfg_num;
                gap_q  <= cfg_gap;
                mode_q <= cfg_mode;
                fill_q <= cfg_fill;
                idx    <= '0;
`ifdef HYDRA_PKT_GEN_LFSR_EN
                lfsr   <= SEED;
`endif
                if (!pause_p) begin
                  sop_q  <= 1'b1;
                  data_q <= '0;
                  state  <= S_DATA;
                end else begin
                  state  <= S_SOP;
                end
              end
            end
          end
          S_SOP: begin
            if (!pause_p) begin
              sop_q  <= 1'b1;
              data_q <= '0;
              idx    <= '0;
`ifdef HYDRA_PKT_GEN_LFSR_EN
              // Reseed per packet so every frame of a run carries the same payload
              lfsr   <= SEED;
`endif
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (!pause_p) begin
              vld_q  <= 1'b1;
              data_q <= (idx == '0) ? {len_q, pri_q, dest_q} : payload;
              idx    <= idx + LEN_W'(1);
`ifdef HYDRA_PKT_GEN_LFSR_EN
              if (idx != '0) begin
                lfsr <= {lfsr_fb, lfsr[15:1]};
              end
`endif
              if (idx == len_q - LEN_W'(1)) begin
                state <= S_EOP;
              end
            end
          end
          S_EOP: begin
            eop_q  <= 1'b1;
            data_q <= '0;
            rem    <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state <= S_IDLE;
            end else if (gap_q == '0) begin
              state <= S_SOP;
            end else begin
              gap_cnt <= gap_q;
              state   <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_cnt == CNT_W'(1)) begin
              state <= S_SOP;
            end else begin
              gap_cnt <= gap_cnt - CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign bus.wr_sop[p]                  = sop_q;
    assign bus.wr_eop[p]                  = eop_q;
    assign bus.wr_vld[p]                  = vld_q;
    assign bus.wr_data[p*DATA_W +: DATA_W] = data_q;
    assign busy[p]                        = (state != S_IDLE);
    assign done[p]                        = done_q;
    assign err[p]                         = err_q;
  end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// tb/tb_hydra_pkt_gen.sv - scoreboard bench for hydra_pkt_gen
module tb_hydra_pkt_gen;

  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] start;
  logic [8:0]    cfg_len;
  logic [2:0]    cfg_pri;
  logic [3:0]    cfg_dest;
  logic [15:0]   cfg_num;
  logic [15:0]   cfg_gap;
  logic [1:0]    cfg_mode;
  logic [15:0]   cfg_fill;
  logic [NP-1:0] pause;
  logic [NP-1:0] busy, done, err;

  hydra_pkt_gen_if #(.NUM_PORTS(NP), .DATA_W(16)) bus ();
  assign bus.pause = pause;

  hydra_pkt_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_pri  (cfg_pri),
    .cfg_dest (cfg_dest),
    .cfg_num  (cfg_num),
    .cfg_gap  (cfg_gap),
    .cfg_mode (cfg_mode),
    .cfg_fill (cfg_fill),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // kind: 0 sop, 1 vld word, 2 eop, 3 done, 4 err
  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t expq [NP][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input int k, input logic [15:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    expq[p].push_back(e);
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (expq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mon_event(input int p, input int k, input logic [15:0] d);
    ev_t e;
    if (expq[p].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event port %0d kind %0d: got event at cycle %0d, required none", p, k, cyc);
      return;
    end
    e = expq[p].pop_front();
    check($sformatf("p%0d_kind", p), k, e.kind);
    check($sformatf("p%0d_k%0d_cycle", p, k), cyc, e.cyc);
    if (k == 1 || k == 2) check($sformatf("p%0d_k%0d_data", p, k), {16'h0, d}, {16'h0, e.data});
  endtask

  // Monitor: every strobe the DUT presents is matched against the front of that port's queue
  logic [4:0] flags;
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      flags = {bus.wr_sop[p], bus.wr_vld[p], bus.wr_eop[p], done[p], err[p]};
      for (int k = 0; k < 5; k++) begin
        if (flags[4-k]) mon_event(p, k, bus.wr_data[p*16 +: 16]);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (!all_empty() && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queues_empty", {31'h0, all_empty()}, 32'h1);
    for (int p = 0; p < NP; p++) expq[p].delete();
    goto(cyc + 3);
  endtask

  task automatic issue(input logic [NP-1:0] mask, input int len, input int pri, input int dest,
                       input int num, input int gap, input int mode, input logic [15:0] fill);
    cfg_len  = 9'(len);
    cfg_pri  = 3'(pri);
    cfg_dest = 4'(dest);
    cfg_num  = 16'(num);
    cfg_gap  = 16'(gap);
    cfg_mode = 2'(mode);
    cfg_fill = fill;
    start    = mask;
    @(posedge clk);
    #1;
    start    = '0;
  endtask

  // Expected frames for a run started at cycle t with no pause; payload for modes 0/2/3 only
  task automatic push_frame(input int p, input int t, input int len, input logic [15:0] hdr,
                            input int num, input int gap, input int mode, input logic [15:0] fill);
    int s;
    logic [15:0] w;
    for (int k = 0; k < num; k++) begin
      s = t + 1 + k * (len + gap + 2);
      push(p, 0, 16'h0, s);
      push(p, 1, hdr, s + 1);
      for (int i = 1; i < len; i++) begin
        w = (mode == 2) ? fill : 16'((p << 12) | i);
        push(p, 1, w, s + 1 + i);
      end
      push(p, 2, 16'h0, s + len + 1);
    end
    push(p, 3, 16'h0, t + 1 + (num - 1) * (len + gap + 2) + len + 2);
  endtask

  initial begin
    int t;
    start = '0; pause = '0;
    cfg_len = '0; cfg_pri = '0; cfg_dest = '0; cfg_num = '0;
    cfg_gap = '0; cfg_mode = '0; cfg_fill = '0;
    goto(3);
    rst_n = 1'b1;

    goto(5);
    check("rst_sop",  {16'h0, bus.wr_sop}, 32'h0);
    check("rst_eop",  {16'h0, bus.wr_eop}, 32'h0);
    check("rst_vld",  {16'h0, bus.wr_vld}, 32'h0);
    check("rst_data", bus.wr_data[31:0], 32'h0);
    check("rst_busy", {16'h0, busy}, 32'h0);
    check("rst_done", {16'h0, done}, 32'h0);
    check("rst_err",  {16'h0, err}, 32'h0);

    // Port 0, len 31, pri 4, dest 3: header {9'd31,3'd4,4'd3} = 16'h0FC3
    goto(10);
    push_frame(0, 10, 31, 16'h0FC3, 1, 0, 0, 16'h0);
    issue(16'h0001, 31, 4, 3, 1, 0, 0, 16'h0);
    check("t1_busy", {31'h0, busy[0]}, 32'h1);
    drain(200);
    check("t1_idle", {31'h0, busy[0]}, 32'h0);

    // Ports 0-2 together, len 5, num 3, gap 2: header {9'd5,3'd1,4'd2} = 16'h0292
    t = cyc;
    for (int p = 0; p < 3; p++) push_frame(p, t, 5, 16'h0292, 3, 2, 0, 16'h0);
    issue(16'h0007, 5, 1, 2, 3, 2, 0, 16'h0);
    drain(200);

    // Port 5, len 8, pause during DATA cycles 4..6: header {9'd8,3'd7,4'd9} = 16'h0479
    t = cyc;
    push(5, 0, 16'h0, t + 1);
    push(5, 1, 16'h0479, t + 2);
    push(5, 1, 16'h5001, t + 3);
    push(5, 1, 16'h5002, t + 4);
    for (int i = 3; i < 8; i++) push(5, 1, 16'(16'h5000 | i), t + 5 + i);
    push(5, 2, 16'h0, t + 13);
    push(5, 3, 16'h0, t + 14);
    issue(16'h0020, 8, 7, 9, 1, 0, 0, 16'h0);
    goto(t + 4);
    pause[5] = 1'b1;
    for (int c = t + 5; c <= t + 7; c++) begin
      goto(c);
      check("t3_pause_vld", {31'h0, bus.wr_vld[5]}, 32'h0);
      check("t3_pause_hold", {16'h0, bus.wr_data[5*16 +: 16]}, 32'h5002);
    end
    pause[5] = 1'b0;
    drain(200);

    // Rejected starts: zero length on port 3, zero count on port 4
    t = cyc;
    push(3, 4, 16'h0, t + 1);
    issue(16'h0008, 0, 1, 1, 2, 0, 0, 16'h0);
    check("t4_busy3", {31'h0, busy[3]}, 32'h0);
    t = cyc;
    push(4, 4, 16'h0, t + 1);
    issue(16'h0010, 4, 1, 1, 0, 0, 0, 16'h0);
    check("t4_busy4", {31'h0, busy[4]}, 32'h0);
    drain(20);

    // Mode 1 on port 0, len 4: header {9'd4,3'd0,4'd0} = 16'h0200
    t = cyc;
    push(0, 0, 16'h0, t + 1);
    push(0, 1, 16'h0200, t + 2);
`ifdef HYDRA_PKT_GEN_LFSR_EN
    push(0, 1, 16'hACE1, t + 3);
    push(0, 1, 16'h5670, t + 4);
    push(0, 1, 16'hAB38, t + 5);
`else
    push(0, 1, 16'h0001, t + 3);
    push(0, 1, 16'h0002, t + 4);
    push(0, 1, 16'h0003, t + 5);
`endif
    push(0, 2, 16'h0, t + 6);
    push(0, 3, 16'h0, t + 7);
    issue(16'h0001, 4, 0, 0, 1, 0, 1, 16'h0);
    drain(50);

    // Mode 2 constant on port 7 (header 16'h01A5) and header-only packet on port 9 (header 16'h008F)
    t = cyc;
    push_frame(7, t, 3, 16'h01A5, 1, 0, 2, 16'hBEEF);
    issue(16'h0080, 3, 2, 5, 1, 0, 2, 16'hBEEF);
    t = cyc;
    push_frame(9, t, 1, 16'h008F, 1, 0, 0, 16'h0);
    issue(16'h0200, 1, 0, 15, 1, 0, 0, 16'h0);
    drain(50);

    // Reset mid-DATA on port 1 (header {9'd8,3'd0,4'd1} = 16'h0401), then a clean restart
    t = cyc;
    push(1, 0, 16'h0, t + 1);
    push(1, 1, 16'h0401, t + 2);
    push(1, 1, 16'h1001, t + 3);
    push(1, 1, 16'h1002, t + 4);
    issue(16'h0002, 8, 0, 1, 1, 0, 0, 16'h0);
    goto(t + 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld",  {16'h0, bus.wr_vld}, 32'h0);
    check("rst_mid_data", bus.wr_data[31:0], 32'h0);
    check("rst_mid_busy", {16'h0, busy}, 32'h0);
    check("rst_mid_eop",  {16'h0, bus.wr_eop}, 32'h0);
    goto(t + 7);
    rst_n = 1'b1;
    goto(t + 9);
    check("rst_mid_queue_done", {31'h0, all_empty()}, 32'h1);
    t = cyc;
    push_frame(1, t, 2, 16'h0111, 1, 0, 0, 16'h0);
    issue(16'h0002, 2, 1, 1, 1, 0, 0, 16'h0);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
